// File: rtl/key_encoder83_if.sv
// Key-code handshake bundle: the encoder drives code/valid, the consumer drives ready.
// A transfer happens on any clock edge where codeValid and codeReady are both high.
interface key_encoder83_if;
  logic [2:0] codeOut;
  logic       codeValid;
  logic       codeReady;

  modport master (output codeOut, output codeValid, input codeReady);
  modport slave  (input codeOut, input codeValid, output codeReady);
endinterface

// File: rtl/key_encoder83.sv
// Debounced 8-to-3 priority encoder: synchronise, debounce the whole vector,
// encode the highest held key and report each new code over a valid/ready handshake.
module key_encoder83 #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             swIn,
  key_encoder83_if.master        code_if,
  output logic                   keyDown,
  output logic                   overrun
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  logic [7:0]       r_s1;
  logic [7:0]       r_s2;
  logic [7:0]       r_cand;
  logic [7:0]       r_stable;
  logic [CNT_W-1:0] r_cnt;

  state_t           r_state;
  logic [2:0]       r_code;
  logic             r_valid;
  logic             r_key_down;
  logic             r_overrun;
  logic [3:0]       r_last;

  logic             w_hit;
  logic [2:0]       w_enc;
  logic             w_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 8'd0;
      r_s2 <= 8'd0;
    end else begin
      r_s1 <= swIn;
      r_s2 <= r_s1;
    end
  end

  // Any difference from the candidate restarts the count; the count then saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand   <= 8'd0;
      r_stable <= 8'd0;
      r_cnt    <= '0;
    end else begin
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    w_enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_stable[i]) w_enc = 3'(i);
    end
  end

  assign w_hit = |r_stable;
  assign w_new = w_hit && ({w_hit, w_enc} != r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_code     <= 3'd0;
      r_valid    <= 1'b0;
      r_key_down <= 1'b0;
      r_overrun  <= 1'b0;
      r_last     <= 4'd0;
    end else begin
      r_key_down <= w_hit;
      r_overrun  <= 1'b0;
      // A full release forgets the last code so the same key can report again.
      if (!w_hit) r_last <= 4'd0;
      case (r_state)
        ST_IDLE: begin
          if (w_new) begin
            r_state <= ST_PEND;
            r_valid <= 1'b1;
            r_code  <= w_enc;
            r_last  <= {1'b1, w_enc};
          end
        end
        ST_PEND: begin
          if (w_new) begin
            r_code    <= w_enc;
            r_last    <= {1'b1, w_enc};
            r_overrun <= !code_if.codeReady;
          end else if (code_if.codeReady) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign code_if.codeOut   = r_code;
  assign code_if.codeValid = r_valid;
  assign keyDown           = r_key_down;
  assign overrun           = r_overrun;

endmodule

// File: tb/tb_key_encoder83.sv
// Directed bench for key_encoder83 with DEBOUNCE_CYCLES=4: a history-window model
// is compared every cycle, and literal expectations pin the scenario milestones.
module tb_key_encoder83;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] swIn = 8'd0;
  logic       keyDown;
  logic       overrun;

  key_encoder83_if bus ();

  key_encoder83 #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .swIn    (swIn),
    .code_if (bus),
    .keyDown (keyDown),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: raw samples history; stable takes a value once DEB+1 consecutive
  // two-stage-synchronised samples agree, outputs follow one edge later.
  logic [7:0] hist [0:DEB+1];
  logic [7:0] m_stable;
  logic [2:0] m_code;
  logic       m_valid, m_keydown, m_overrun, m_last_valid;
  logic [2:0] m_last_code;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= DEB + 1; k++) hist[k] = 8'd0;
      m_stable = 8'd0; m_code = 3'd0; m_valid = 1'b0; m_keydown = 1'b0;
      m_overrun = 1'b0; m_last_valid = 1'b0; m_last_code = 3'd0;
    end else begin
      bit hit, fresh, same;
      int enc;
      hit   = (m_stable != 8'd0);
      enc   = hit ? ($clog2(int'(m_stable) + 1) - 1) : 0;
      fresh = hit && !(m_last_valid && (int'(m_last_code) == enc));
      m_overrun = fresh && m_valid && !bus.codeReady;
      m_keydown = hit;
      if (!hit) m_last_valid = 1'b0;
      if (fresh) begin
        m_code = 3'(enc); m_last_valid = 1'b1; m_last_code = 3'(enc); m_valid = 1'b1;
      end else if (m_valid && bus.codeReady) begin
        m_valid = 1'b0;
      end
      same = 1'b1;
      for (int k = 1; k <= DEB + 1; k++) if (hist[k] != hist[1]) same = 1'b0;
      if (same) m_stable = hist[2];
      for (int k = DEB + 1; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = swIn;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model codeOut",   int'(bus.codeOut),   int'(m_code));
      check("model codeValid", int'(bus.codeValid), int'(m_valid));
      check("model keyDown",   int'(keyDown),       int'(m_keydown));
      check("model overrun",   int'(overrun),       int'(m_overrun));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic accept();
    bus.codeReady = 1'b1;
    step(1);
    bus.codeReady = 1'b0;
    check("accept drops valid", int'(bus.codeValid), 0);
  endtask

  task automatic expect_code(input string name, input int code, input int ovr);
    check({name, " valid"}, int'(bus.codeValid), 1);
    check({name, " code"}, int'(bus.codeOut), code);
    check({name, " overrun"}, int'(overrun), ovr);
  endtask

  initial begin
    bus.codeReady = 1'b0;
    step(3);
    rst_n = 1'b1;
    check("reset codeValid", int'(bus.codeValid), 0);
    check("reset codeOut", int'(bus.codeOut), 0);
    check("reset keyDown", int'(keyDown), 0);
    step(10);

    // Single press, then release and re-press the same key.
    swIn = 8'h08;
    step(7);
    check("press edge7 valid", int'(bus.codeValid), 0);
    step(1);
    expect_code("press edge8", 3, 0);
    check("press keyDown", int'(keyDown), 1);
    step(2);
    accept();
    swIn = 8'h00;
    step(8);
    check("release keyDown", int'(keyDown), 0);
    check("release valid", int'(bus.codeValid), 0);
    swIn = 8'h08;
    step(8);
    expect_code("repress", 3, 0);
    accept();

    // Priority.
    swIn = 8'h81;
    step(8);
    expect_code("prio 81", 7, 0);
    accept();
    swIn = 8'h80;
    step(12);
    check("drop low key no event", int'(bus.codeValid), 0);
    swIn = 8'h01;
    step(8);
    expect_code("prio 01", 0, 0);
    accept();
    swIn = 8'h00;
    step(10);

    // Bounce on bit 2, final toggle leaves it high.
    for (int i = 0; i < 10; i++) begin
      swIn = (i % 2 == 0) ? 8'h04 : 8'h00;
      step(3);
      check("bounce no event", int'(bus.codeValid), 0);
    end
    swIn = 8'h04;
    step(7);
    check("bounce edge7 valid", int'(bus.codeValid), 0);
    step(1);
    expect_code("bounce settle", 2, 0);
    accept();
    swIn = 8'h00;
    step(10);

    // Overwrite without acceptance.
    swIn = 8'h02;
    step(8);
    expect_code("ovr first", 1, 0);
    swIn = 8'h22;
    step(8);
    expect_code("ovr second", 5, 1);
    step(1);
    check("ovr pulse ends", int'(overrun), 0);
    accept();
    swIn = 8'h00;
    step(10);

    // Overwrite with simultaneous acceptance.
    swIn = 8'h02;
    step(8);
    expect_code("simul first", 1, 0);
    swIn = 8'h22;
    step(7);
    bus.codeReady = 1'b1;
    step(1);
    bus.codeReady = 1'b0;
    expect_code("simul second", 5, 0);
    step(1);
    check("simul still valid", int'(bus.codeValid), 1);
    accept();
    swIn = 8'h00;
    step(10);

    // One-hot sweep.
    for (int b = 0; b < 8; b++) begin
      swIn = 8'(1 << b);
      step(8);
      expect_code("sweep", b, 0);
      accept();
    end

    // Asynchronous reset mid-cycle while a code is pending.
    swIn = 8'h08;
    step(10);
    expect_code("pre-reset", 3, 0);
    #1;
    rst_n = 1'b0;
    swIn  = 8'h00;
    #1;
    check("async reset valid", int'(bus.codeValid), 0);
    check("async reset code", int'(bus.codeOut), 0);
    check("async reset keyDown", int'(keyDown), 0);
    check("async reset overrun", int'(overrun), 0);
    step(2);
    rst_n = 1'b1;
    step(12);
    check("post-reset valid", int'(bus.codeValid), 0);
    check("post-reset keyDown", int'(keyDown), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
